// File: rtl/wb_mon_pkg.sv
// rtl/wb_mon_pkg.sv - shared check encodings and types for the Wishbone protocol monitor
// Contents:
//   chk_e      bit index of each protocol check inside a check vector
//   N_CHK      number of checks
//   chk_vec_t  one bit per check
//   ptr_width  pointer width for a power-of-two FIFO depth (minimum 1 bit)
package wb_mon_pkg;

   typedef enum logic [2:0] {
      RSP_NO_REQ   = 3'd0,
      ACK_AND_ERR  = 3'd1,
      TIMEOUT      = 3'd2,
      OVERFLOW     = 3'd3,
      CYC_DROP     = 3'd4,
      STALL_CHANGE = 3'd5,
      RSP_NO_CYC   = 3'd6
   } chk_e;

   localparam int N_CHK = 7;

   typedef logic [N_CHK-1:0] chk_vec_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_mon_ts_fifo.sv
// rtl/wb_mon_ts_fifo.sv - timestamp FIFO tracking accept times of outstanding requests
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   flush       drop every entry (pointers and count back to 0)
//   push, din   store an accept timestamp at the tail
//   pop         retire the head entry
//   set_fired   mark the head entry as already reported for timeout
//   head        timestamp of the oldest entry
//   fired       timeout-reported flag of the head entry
//   count       number of stored entries
// The caller never pushes when full nor pops when empty.
module wb_mon_ts_fifo
   import wb_mon_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int TS_W   = 6,
   localparam int PTR_W  = ptr_width(DEPTH),
   localparam int CNT_OW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic              set_fired,
   input  logic [TS_W-1:0]   din,
   output logic [TS_W-1:0]   head,
   output logic              fired,
   output logic [CNT_OW-1:0] count
);

   // Storage is rounded up to 2**PTR_W so pointers wrap by plain overflow,
   // including the single-entry case.
   logic [TS_W-1:0]  mem [2**PTR_W];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fired  <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         fired  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // A new head starts unreported; retiring wins over marking.
         if (pop) begin
            fired <= 1'b0;
         end else if (set_fired) begin
            fired <= 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_protocol_monitor.sv
// rtl/wb_protocol_monitor.sv - passive Wishbone B4 pipelined protocol checker
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cyc, stb, we, adr, sel, dat_m  tapped master signals
//   stall, ack, err                tapped slave signals
//   chk_en                         per-check enable mask
//   clr                            synchronous clear of sticky flags, counter, capture
//   err_pulse                      registered, masked violation vector
//   err_sticky                     accumulated err_pulse
//   err_count                      saturating count of cycles with any violation
//   first_valid/code/adr           capture of the first violating cycle
//   outstanding                    accepted but unanswered requests
module wb_protocol_monitor
   import wb_mon_pkg::*;
#(
   parameter  int ADR_W       = 32,
   parameter  int DAT_W       = 32,
   parameter  int MAX_OUT     = 4,
   parameter  int MAXWAITS    = 16,
   parameter  int CNT_W       = 16,
   parameter  int ALLOW_ABORT = 1,
   localparam int SEL_W       = DAT_W / 8,
   localparam int OCNT_W      = $clog2(MAX_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cyc,
   input  logic              stb,
   input  logic              we,
   input  logic [ADR_W-1:0]  adr,
   input  logic [SEL_W-1:0]  sel,
   input  logic [DAT_W-1:0]  dat_m,
   input  logic              stall,
   input  logic              ack,
   input  logic              err,
   input  chk_vec_t          chk_en,
   input  logic              clr,
   output chk_vec_t          err_pulse,
   output chk_vec_t          err_sticky,
   output logic [CNT_W-1:0]  err_count,
   output logic              first_valid,
   output chk_vec_t          first_code,
   output logic [ADR_W-1:0]  first_adr,
   output logic [OCNT_W-1:0] outstanding
);

   // Two spare bits keep the timeout age well clear of modulo wrap.
   localparam int                TS_W      = $clog2(MAXWAITS) + 2;
   localparam logic [TS_W-1:0]   TO_AGE    = TS_W'(MAXWAITS + 1);
   localparam logic [OCNT_W-1:0] FULL_CNT  = OCNT_W'(MAX_OUT);
   localparam logic              ABORT_CHK = (ALLOW_ABORT == 0);

   logic              req, rsp, empty, full, push, pop, timeout_hit;
   logic [TS_W-1:0]   ts, head_ts, age;
   logic              head_fired;
   logic [OCNT_W-1:0] cnt;
   chk_vec_t          raw, pulse_d;

   logic              hold_valid, hold_we;
   logic [ADR_W-1:0]  hold_adr;
   logic [SEL_W-1:0]  hold_sel;
   logic [DAT_W-1:0]  hold_dat;

   assign req   = cyc & stb & ~stall;
   assign rsp   = cyc & (ack | err);
   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   // A response with nothing outstanding is only reported, never popped.
   assign pop   = rsp & ~empty;
   // When full, a push is only possible if the head retires in the same cycle.
   assign push  = req & ~(full & ~rsp);
   assign age   = ts - head_ts;
   assign timeout_hit = cyc & ~empty & (age == TO_AGE) & ~head_fired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts <= '0;
      else     ts <= ts + 1'b1;
   end

   wb_mon_ts_fifo #(
      .DEPTH (MAX_OUT),
      .TS_W  (TS_W)
   ) u_ts_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (~cyc),
      .push      (push),
      .pop       (pop),
      .set_fired (timeout_hit),
      .din       (ts),
      .head      (head_ts),
      .fired     (head_fired),
      .count     (cnt)
   );

   // Snapshot of a stalled request; the master must hold it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_we    <= 1'b0;
         hold_adr   <= '0;
         hold_sel   <= '0;
         hold_dat   <= '0;
      end else begin
         hold_valid <= cyc & stb & stall;
         hold_we    <= we;
         hold_adr   <= adr;
         hold_sel   <= sel;
         hold_dat   <= dat_m;
      end
   end

   always_comb begin
      raw = '0;
      raw[RSP_NO_REQ]   = rsp & empty;
      raw[ACK_AND_ERR]  = cyc & ack & err;
      raw[TIMEOUT]      = timeout_hit;
      raw[OVERFLOW]     = req & full & ~rsp;
      raw[CYC_DROP]     = ~cyc & ~empty & ABORT_CHK;
      raw[STALL_CHANGE] = hold_valid &
                          (~(cyc & stb) | (adr != hold_adr) | (we != hold_we) |
                           (hold_we & ((sel != hold_sel) | (dat_m != hold_dat))));
      raw[RSP_NO_CYC]   = (ack | err) & ~cyc;
      pulse_d = raw & chk_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_pulse   <= '0;
         err_sticky  <= '0;
         err_count   <= '0;
         first_valid <= 1'b0;
         first_code  <= '0;
         first_adr   <= '0;
      end else begin
         err_pulse <= pulse_d;
         if (clr) begin
            err_sticky  <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_code  <= '0;
            first_adr   <= '0;
         end else begin
            err_sticky <= err_sticky | pulse_d;
            if ((|pulse_d) && (err_count != '1)) begin
               err_count <= err_count + 1'b1;
            end
            if ((|pulse_d) && !first_valid) begin
               first_valid <= 1'b1;
               first_code  <= pulse_d;
               first_adr   <= adr;
            end
         end
      end
   end

   assign outstanding = cnt;

endmodule
